// File: rtl/smem_pkg.sv
// Shared types and sizing for the screen-memory port controller.
package smem_pkg;

    // 80x60 tiles, 4 bits each
    localparam int unsigned SMEM_NLOC  = 4800;
    localparam int unsigned SMEM_DBITS = 4;

    // Fill engine states
    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } fill_state_t;

    // Identity of the requester that owned the port most recently
    typedef enum logic {
        GNT_CPU,
        GNT_FILL
    } grant_t;

endpackage

// File: rtl/smem_ctrl_if.sv
// Bundle of CPU, fill-engine and screen-memory signals around smem_ctrl.
// The master side is the surrounding system (CPU, maze generator, memory);
// the slave side is the controller itself.
interface smem_ctrl_if
    import smem_pkg::*;
#(
    parameter int unsigned Nloc  = SMEM_NLOC,
    parameter int unsigned Dbits = SMEM_DBITS
);
    localparam int unsigned Aw = $clog2(Nloc);
    localparam int unsigned Lw = $clog2(Nloc + 1);

    // CPU access port
    logic             cpu_req;
    logic             cpu_we;
    logic [Aw-1:0]    cpu_addr;
    logic [Dbits-1:0] cpu_wdata;
    logic             cpu_ack;
    logic [Dbits-1:0] cpu_rdata;

    // Fill engine command/status
    logic             fill_start;
    logic [Aw-1:0]    fill_base;
    logic [Lw-1:0]    fill_len;
    logic [Dbits-1:0] fill_value;
    logic             fill_busy;
    logic             fill_done;
    logic             fill_err;

    // Screen memory CPU-side port
    logic             smem_wr;
    logic [Aw-1:0]    smem_addr;
    logic [Dbits-1:0] smem_wdata;
    logic [Dbits-1:0] smem_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output fill_start, fill_base, fill_len, fill_value,
        output smem_rdata,
        input  cpu_ack, cpu_rdata,
        input  fill_busy, fill_done, fill_err,
        input  smem_wr, smem_addr, smem_wdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  fill_start, fill_base, fill_len, fill_value,
        input  smem_rdata,
        output cpu_ack, cpu_rdata,
        output fill_busy, fill_done, fill_err,
        output smem_wr, smem_addr, smem_wdata
    );

endinterface

// File: rtl/smem_rr_arb.sv
// Two-requester round-robin arbiter. req_i[0]/gnt_o[0] is the CPU,
// req_i[1]/gnt_o[1] is the fill engine. Grant is combinational; only the
// identity of the last winner is registered.
module smem_rr_arb
    import smem_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    grant_t last_q, last_d;

    // Grant the sole requester, or on conflict whoever did not win last time
    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b00: gnt_o = 2'b00;
            2'b01: gnt_o = 2'b01;
            2'b10: gnt_o = 2'b10;
            2'b11: gnt_o = (last_q == GNT_FILL) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    // History only moves on cycles that actually granted someone
    always_comb begin
        last_d = last_q;
        if (gnt_o[0]) begin
            last_d = GNT_CPU;
        end else if (gnt_o[1]) begin
            last_d = GNT_FILL;
        end
    end

    // Reset to FILL so the CPU wins the first conflict
    always_ff @(posedge clock) begin
        if (reset) begin
            last_q <= GNT_FILL;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/smem_ctrl.sv
// Screen-memory CPU-side port owner: arbitrates between CPU accesses and a
// fill engine that writes one tile value over a wrapping address range.
module smem_ctrl
    import smem_pkg::*;
#(
    parameter int unsigned Nloc  = SMEM_NLOC,
    parameter int unsigned Dbits = SMEM_DBITS
) (
    input logic        clock,
    input logic        reset,
    smem_ctrl_if.slave bus
);

    localparam int unsigned   Aw       = $clog2(Nloc);
    localparam int unsigned   Lw       = $clog2(Nloc + 1);
    localparam logic [Aw-1:0] LastAddr = Aw'(Nloc - 1);
    localparam logic [Aw-1:0] AddrOne  = Aw'(1);
    localparam logic [Lw-1:0] LenOne   = Lw'(1);

    fill_state_t      state_q, state_d;
    logic [Aw-1:0]    ptr_q, ptr_d;
    logic [Lw-1:0]    rem_q, rem_d;
    logic [Dbits-1:0] val_q, val_d;
    logic             err_q, err_d;

    logic             fill_req;
    logic [1:0]       arb_req;
    logic [1:0]       arb_gnt;
    logic             cpu_gnt;
    logic             fill_gnt;
    logic             done_pulse;
    logic             err_pulse;

    logic             smem_wr;
    logic [Aw-1:0]    smem_addr;
    logic [Dbits-1:0] smem_wdata;
    logic             cpu_ack;
    logic [Dbits-1:0] cpu_rdata;

    assign fill_req = (state_q == FILL);

    // Requests are masked in reset so nothing reaches the memory port
    assign arb_req  = {fill_req, bus.cpu_req} & {2{~reset}};

    smem_rr_arb u_arb (
        .clock (clock),
        .reset (reset),
        .req_i (arb_req),
        .gnt_o (arb_gnt)
    );

    assign cpu_gnt  = arb_gnt[0];
    assign fill_gnt = arb_gnt[1];

    // Fill FSM next-state: latch command, step pointer on each grant
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        val_d      = val_q;
        err_d      = err_q;
        done_pulse = 1'b0;
        err_pulse  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.fill_start) begin
                    if (bus.fill_base > LastAddr) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (bus.fill_len == '0) begin
                        state_d = DONE;
                    end else begin
                        ptr_d   = bus.fill_base;
                        rem_d   = bus.fill_len;
                        val_d   = bus.fill_value;
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (fill_gnt) begin
                    ptr_d = (ptr_q == LastAddr) ? '0 : ptr_q + AddrOne;
                    rem_d = rem_q - LenOne;
                    if (rem_q == LenOne) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done_pulse = 1'b1;
                err_pulse  = err_q;
                err_d      = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Fill FSM state and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            val_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            val_q   <= val_d;
            err_q   <= err_d;
        end
    end

    // Port mux: winner drives the memory; idle port parks on the CPU address
    always_comb begin
        smem_wr    = 1'b0;
        smem_addr  = bus.cpu_addr;
        smem_wdata = bus.cpu_wdata;
        cpu_ack    = 1'b0;
        cpu_rdata  = '0;
        if (cpu_gnt) begin
            smem_wr   = bus.cpu_we;
            cpu_ack   = 1'b1;
            cpu_rdata = bus.smem_rdata;
        end else if (fill_gnt) begin
            smem_wr    = 1'b1;
            smem_addr  = ptr_q;
            smem_wdata = val_q;
        end
    end

    assign bus.smem_wr    = smem_wr;
    assign bus.smem_addr  = smem_addr;
    assign bus.smem_wdata = smem_wdata;
    assign bus.cpu_ack    = cpu_ack;
    assign bus.cpu_rdata  = cpu_rdata;

    // Completion pulses are suppressed in reset so an abandoned fill stays silent
    assign bus.fill_busy  = (state_q == FILL);
    assign bus.fill_done  = done_pulse & ~reset;
    assign bus.fill_err   = err_pulse & ~reset;

endmodule

// File: tb/tb_smem_ctrl.sv
// Self-checking bench for smem_ctrl: directed scenarios plus randomized
// fills with concurrent CPU traffic, against a shadow-memory model.
module tb_smem_ctrl;

    localparam int NLOC = 4800;
    localparam int AW   = 13;

    logic clock;
    logic reset;

    smem_ctrl_if bus ();

    smem_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Screen memory: asynchronous read, write on the clock edge
    logic [3:0] mem [NLOC];
    assign bus.smem_rdata = mem[bus.smem_addr];
    always @(posedge clock) begin
        if (bus.smem_wr && int'(bus.smem_addr) < NLOC) mem[bus.smem_addr] <= bus.smem_wdata;
    end

    logic [3:0] model_mem [NLOC];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t0 = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic done_err = 1'b0;
    int busy_acks = 0;
    int wait_run = 0;
    int max_wait = 0;
    int wr_addr_q[$];
    int wr_val_q[$];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc++;

    // Observe fill writes, completion pulses and CPU waiting at mid-cycle
    always @(negedge clock) begin
        if (bus.smem_wr && !bus.cpu_ack) begin
            wr_addr_q.push_back(int'(bus.smem_addr));
            wr_val_q.push_back(int'(bus.smem_wdata));
        end
        if (bus.fill_done) begin
            done_cnt++;
            done_cyc = cyc;
            done_err = bus.fill_err;
        end
        if (bus.cpu_ack && bus.fill_busy) busy_acks++;
        if (bus.cpu_req && !bus.cpu_ack && !reset) begin
            wait_run++;
            if (wait_run > max_wait) max_wait = wait_run;
        end else begin
            wait_run = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        wr_addr_q.delete();
        wr_val_q.delete();
        busy_acks = 0;
    endtask

    task automatic start_fill(input int base, input int len, input int val);
        @(posedge clock); #1;
        bus.fill_start = 1'b1;
        bus.fill_base  = AW'(base);
        bus.fill_len   = AW'(len);
        bus.fill_value = 4'(val);
        t0 = cyc;
        @(posedge clock); #1;
        bus.fill_start = 1'b0;
    endtask

    task automatic cpu_op(input logic we, input int addr, input int wd,
                          output logic [3:0] rd, output int waits, output logic wr_seen);
        logic got;
        got = 1'b0;
        @(posedge clock); #1;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = AW'(addr);
        bus.cpu_wdata = 4'(wd);
        waits = 0;
        rd = '0;
        wr_seen = 1'b0;
        while (!got && waits < 8) begin
            @(negedge clock); #1;
            if (bus.cpu_ack) begin
                got = 1'b1;
                rd = bus.cpu_rdata;
                wr_seen = bus.smem_wr;
            end else begin
                waits++;
            end
        end
        check("cpu ack seen", 32'(got), 32'd1);
        @(posedge clock); #1;
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0, input int bound);
        int n;
        n = 0;
        while (done_cnt == d0 && n < bound) begin
            @(negedge clock); #1;
            n++;
        end
        check({tag, " done seen"}, 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic check_fill(input string tag, input int base, input int len, input int val);
        int bad;
        bad = 0;
        check({tag, " write count"}, wr_addr_q.size(), len);
        for (int i = 0; i < wr_addr_q.size(); i++) begin
            if (wr_addr_q[i] != (base + i) % NLOC || wr_val_q[i] != val) bad++;
        end
        check({tag, " write sequence"}, bad, 0);
    endtask

    task automatic finish_fill(input string tag, input int base, input int len, input int val,
                               input int dur, input logic err, input int d0);
        wait_done(tag, d0, 2 * len + 20);
        check({tag, " duration"}, done_cyc - t0, dur);
        check({tag, " err"}, 32'(done_err), 32'(err));
        check_fill(tag, base, len, val);
        repeat (3) begin @(negedge clock); #1; end
        check({tag, " single done"}, done_cnt - d0, 1);
        check({tag, " busy low"}, 32'(bus.fill_busy), 32'd0);
    endtask

    initial begin
        logic [3:0] rd;
        int w;
        logic wrs;
        int d0;
        int n;
        int bad;
        int base;
        int len;
        int val;
        int a;
        int wd;
        logic we;

        // Reset with requests pending: port must stay quiet
        reset = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.fill_start = 1'b1; bus.fill_base = '0; bus.fill_len = AW'(5); bus.fill_value = '0;
        repeat (2) begin @(negedge clock); #1; end
        check("reset cpu_ack", 32'(bus.cpu_ack), 32'd0);
        check("reset smem_wr", 32'(bus.smem_wr), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.fill_start = 1'b0;
        @(negedge clock); #1;
        check("reset fill_busy", 32'(bus.fill_busy), 32'd0);
        check("reset fill_done", 32'(bus.fill_done), 32'd0);
        check("reset fill_err", 32'(bus.fill_err), 32'd0);

        // CPU only
        cpu_op(1'b1, 100, 'hA, rd, w, wrs);
        check("cpu write wait", w, 0);
        check("cpu write smem_wr", 32'(wrs), 32'd1);
        cpu_op(1'b0, 100, 0, rd, w, wrs);
        check("cpu read wait", w, 0);
        check("cpu read smem_wr", 32'(wrs), 32'd0);
        check("cpu read data", 32'(rd), 32'hA);

        // Fill alone
        clear_obs(); d0 = done_cnt;
        start_fill(10, 5, 3);
        finish_fill("fill alone", 10, 5, 3, 6, 1'b0, d0);

        // Wrap around the top of memory
        clear_obs(); d0 = done_cnt;
        start_fill(4798, 4, 7);
        finish_fill("wrap", 4798, 4, 7, 5, 1'b0, d0);

        // Contention: fill start and CPU write in the same cycle
        clear_obs(); d0 = done_cnt;
        @(posedge clock); #1;
        bus.fill_start = 1'b1; bus.fill_base = '0; bus.fill_len = AW'(4); bus.fill_value = 4'd1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = AW'(200); bus.cpu_wdata = 4'd5;
        t0 = cyc;
        @(negedge clock); #1;
        check("contention cpu ack cycle0", 32'(bus.cpu_ack), 32'd1);
        check("contention cpu smem_wr", 32'(bus.smem_wr), 32'd1);
        @(posedge clock); #1;
        bus.fill_start = 1'b0; bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        finish_fill("contention", 0, 4, 1, 5, 1'b0, d0);
        check("contention mem200", 32'(mem[200]), 32'd5);

        // Zero length and out-of-range base
        clear_obs(); d0 = done_cnt;
        start_fill(20, 0, 6);
        finish_fill("len zero", 20, 0, 6, 1, 1'b0, d0);
        clear_obs(); d0 = done_cnt;
        start_fill(4800, 5, 3);
        finish_fill("base oob", 4800, 0, 3, 1, 1'b1, d0);

        // Start while busy is ignored
        clear_obs(); d0 = done_cnt;
        start_fill(500, 10, 2);
        @(posedge clock); #1;
        bus.fill_start = 1'b1; bus.fill_base = AW'(600); bus.fill_len = AW'(5);
        bus.fill_value = 4'd6;
        @(posedge clock); #1;
        bus.fill_start = 1'b0;
        finish_fill("busy ignore", 500, 10, 2, 11, 1'b0, d0);

        // Reset mid-fill, after a CPU grant so the arbiter history is CPU
        clear_obs(); d0 = done_cnt;
        start_fill(0, 100, 4);
        n = 0;
        while (wr_addr_q.size() < 20 && n < 200) begin @(negedge clock); #1; n++; end
        check("rst writes before", wr_addr_q.size(), 20);
        cpu_op(1'b0, 4000, 0, rd, w, wrs);
        check("rst cpu wait", w, 0);
        reset = 1'b1;
        @(negedge clock); #1;
        check("rst smem_wr gated", 32'(bus.smem_wr), 32'd0);
        check("rst cpu_ack gated", 32'(bus.cpu_ack), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (5) begin @(negedge clock); #1; end
        check("rst no further writes", wr_addr_q.size(), 20);
        check("rst no done", done_cnt - d0, 0);
        check("rst busy low", 32'(bus.fill_busy), 32'd0);

        // First conflict after reset goes to the CPU
        clear_obs(); d0 = done_cnt;
        start_fill(300, 3, 8);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = AW'(4001);
        @(negedge clock); #1;
        check("post-rst conflict cpu ack", 32'(bus.cpu_ack), 32'd1);
        @(posedge clock); #1;
        bus.cpu_req = 1'b0;
        finish_fill("post-rst fill", 300, 3, 8, 5, 1'b0, d0);

        // Full screen
        clear_obs(); d0 = done_cnt;
        start_fill(0, NLOC, 9);
        finish_fill("full screen", 0, NLOC, 9, NLOC + 1, 1'b0, d0);
        for (int i = 0; i < NLOC; i++) model_mem[i] = 4'd9;
        bad = 0;
        for (int i = 0; i < NLOC; i++) if (mem[i] !== model_mem[i]) bad++;
        check("full screen contents", bad, 0);

        // Random fills with CPU traffic outside the fill range
        for (int it = 0; it < 6; it++) begin
            base = int'($urandom_range(0, NLOC - 1));
            len  = int'($urandom_range(1, 200));
            val  = int'($urandom_range(0, 15));
            clear_obs(); d0 = done_cnt;
            start_fill(base, len, val);
            bad = 0; n = 0;
            while (done_cnt == d0 && n < 400) begin
                a  = (base + len + int'($urandom_range(0, NLOC - 1 - len))) % NLOC;
                we = 1'($urandom_range(0, 1));
                wd = int'($urandom_range(0, 15));
                cpu_op(we, a, wd, rd, w, wrs);
                if (we) model_mem[a] = 4'(wd);
                else if (rd !== model_mem[a]) bad++;
                n++;
            end
            wait_done("random", d0, 2 * len + 20);
            check("random cpu reads", bad, 0);
            check("random duration", done_cyc - t0, len + busy_acks + 1);
            check_fill("random", base, len, val);
            for (int i = 0; i < len; i++) model_mem[(base + i) % NLOC] = 4'(val);
            repeat (2) begin @(negedge clock); #1; end
            bad = 0;
            for (int i = 0; i < NLOC; i++) if (mem[i] !== model_mem[i]) bad++;
            check("random contents", bad, 0);
        end
        check("cpu max wait le 1", 32'(max_wait <= 1), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/smem_ctrl.md
Name: smem_ctrl

Overview:
- Owns the single CPU-side port (write enable, address, write data, read data) of the screen memory.
- Arbitrates that port between CPU read/write requests and a built-in fill engine.
- The fill engine writes one tile value across a contiguous, wrapping address range, used for screen clear and region fill in maze generation.
- Sits between the CPU/maze-generator logic and the screen memory; the VGA read port is untouched.

Parameters:
- Nloc, 4800, number of screen memory locations (80x60 tiles).
- Dbits, 4, bits per location.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU requests a port access this cycle
- cpu_we  in  1  1 = write, 0 = read (valid with cpu_req)
- cpu_addr  in  $clog2(Nloc)  CPU address
- cpu_wdata  in  Dbits  CPU write data
- cpu_ack  out  1  access performed this cycle (combinational)
- cpu_rdata  out  Dbits  read data, valid when cpu_ack && !cpu_we
- fill_start  in  1  pulse: begin fill
- fill_base  in  $clog2(Nloc)  first address
- fill_len  in  $clog2(Nloc+1)  number of locations, 0..Nloc
- fill_value  in  Dbits  value written
- fill_busy  out  1  fill in progress
- fill_done  out  1  one-cycle pulse at fill completion
- fill_err  out  1  one-cycle pulse with fill_done when fill_base >= Nloc
- smem_wr  out  1  to screen memory write enable
- smem_addr  out  $clog2(Nloc)  to screen memory CPU-side address
- smem_wdata  out  Dbits  to screen memory write data
- smem_rdata  in  Dbits  from screen memory CPU-side read data (asynchronous)

Behaviour:
- Fill FSM has three states, IDLE, FILL and DONE. Reset value is IDLE, with fill_busy=0, fill_done=0 and fill_err=0.
- **IDLE:**
  - fill_start with fill_len=0 goes to DONE with no writes.
  - fill_start with fill_base>=Nloc goes to DONE with err_q set and no writes.
  - Otherwise fill_start latches base, len and value into ptr, remaining (rem) and val, then goes to FILL.
- **FILL:** fill_busy=1; fill_req is asserted.
  - On each fill grant: write val at ptr, then advance ptr (Nloc-1 wraps to 0) and decrement rem.
  - Grant with rem==1 goes to DONE.
- **DONE:** lasts exactly one cycle, with fill_done=1 and fill_err=err_q. It then goes to IDLE and clears err_q.
- fill_start outside IDLE is ignored, with no requeue; fill_start in DONE is also ignored.
- **Arbitration** (combinational grant, registered last_grant):
  - Only one requester: grant it.
  - Both requesting: grant the one that was not last granted.
  - last_grant resets to FILL, so the CPU wins the first conflict.
  - last_grant updates only on a cycle with a grant.
- **Port mux:**
  - CPU grant: smem_addr=cpu_addr; smem_wr=cpu_we; smem_wdata=cpu_wdata; cpu_ack=1; cpu_rdata=smem_rdata.
  - Fill grant: smem_addr=ptr; smem_wr=1; smem_wdata=val; cpu_ack=0.
  - No grant: smem_wr=0, smem_addr=cpu_addr, cpu_ack=0.
- CPU read latency is 0 cycles (same-cycle ack and data). A write commits at the clock edge ending the ack cycle.
- A CPU must hold cpu_req and its operands until cpu_ack. Worst-case CPU wait is 1 cycle.
- Fill throughput:
  - 1 write/cycle with no CPU traffic.
  - At least 1 write per 2 cycles under continuous CPU requests.
  - Total fill duration = fill_len + CPU grants taken during FILL.
- While reset=1:
  - smem_wr=0 and cpu_ack=0, regardless of requests.
  - The FSM goes to IDLE at the edge and last_grant goes to FILL.
  - A fill in progress is abandoned with no further writes and no fill_done pulse.
- Full-screen fill: fill_len=Nloc with any base writes every location exactly once, wrapping.

Decomposition:
- Package smem_pkg holds:
  - typedef fill_state_t {IDLE, FILL, DONE}
  - typedef grant_t {GNT_CPU, GNT_FILL}
  - localparams SMEM_NLOC=4800, SMEM_DBITS=4
- One sub-module is natural: smem_rr_arb, a 2-requester round-robin arbiter with req[1:0] in, one-hot gnt[1:0] out, and the last_grant register.
- The fill FSM and port mux stay in smem_ctrl.

Test Plan:
- **CPU only:** write 4'hA at addr 100, then read 100. Expect cpu_ack the same cycle both times, smem_wr=1 only on the write, and cpu_rdata=4'hA.
- **Fill alone:** base=10, len=5, value=3. Expect smem_wr high for 5 consecutive cycles at addresses 10..14, then a single fill_done pulse with fill_busy low afterwards.
- **Wrap and full screen:**
  - base=4798, len=4, value=7: writes go to 4798, 4799, 0, 1.
  - base=0, len=4800: 4800 writes, then fill_done.
- **Contention:** start fill base=0, len=4, and hold a CPU write at addr 200 from the same cycle. Expect grants in order CPU, FILL; the CPU is acked in cycle 0 and the fill completes 5 cycles after start.
- **Edge cases:**
  - fill_len=0: fill_done the cycle after start, no writes.
  - fill_base=4800: fill_done and fill_err pulse, no writes.
  - fill_start while busy: ignored.
- **Reset mid-fill:** base=0, len=100; assert reset after 20 writes. Expect no writes and no fill_done thereafter, fill_busy=0, and the next conflict granted to the CPU.
